// File: rtl/rf_wb_scheduler_if.sv
// rtl/rf_wb_scheduler_if.sv - issue, write-back request and RF write-port bundle
// The scheduler uses the slave side; decode/ALU/LSU/RF sit on the master side.
interface rf_wb_scheduler_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREGS  = 32
);
  logic              iss_valid;
  logic [ADDR_W-1:0] iss_rs0;
  logic [ADDR_W-1:0] iss_rs1;
  logic [ADDR_W-1:0] iss_rd;
  logic              iss_rd_we;
  logic              iss_ready;

  logic              alu_valid;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_wdata;
  logic              alu_ready;

  logic              lsu_valid;
  logic [ADDR_W-1:0] lsu_rd;
  logic [DATA_W-1:0] lsu_wdata;
  logic              lsu_ready;

  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              rf_we;
  logic [NREGS-1:0]  pending;
  logic              wb_err;

  modport master (
    output iss_valid, iss_rs0, iss_rs1, iss_rd, iss_rd_we,
    input  iss_ready,
    output alu_valid, alu_rd, alu_wdata,
    input  alu_ready,
    output lsu_valid, lsu_rd, lsu_wdata,
    input  lsu_ready,
    input  rf_waddr, rf_wdata, rf_we, pending, wb_err
  );

  modport slave (
    input  iss_valid, iss_rs0, iss_rs1, iss_rd, iss_rd_we,
    output iss_ready,
    input  alu_valid, alu_rd, alu_wdata,
    output alu_ready,
    input  lsu_valid, lsu_rd, lsu_wdata,
    output lsu_ready,
    output rf_waddr, rf_wdata, rf_we, pending, wb_err
  );
endinterface

// File: rtl/rf_wb_scheduler.sv
// rtl/rf_wb_scheduler.sv - RF write-port arbiter with RAW/WAW hazard scoreboard
// ALU/LSU share one registered write port; pending bits stall decode until commit.
module rf_wb_scheduler #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREGS  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  rf_wb_scheduler_if.slave  wb
);

  logic              prio_alu;
  logic              alu_gnt;
  logic              lsu_gnt;
  logic              gnt;
  logic              contended;
  logic [ADDR_W-1:0] gnt_rd;
  logic [DATA_W-1:0] gnt_wdata;

  logic              iss_fire;
  logic              hazard;
  logic [NREGS-1:0]  pend_q;
  logic [NREGS-1:0]  pend_set;
  logic [NREGS-1:0]  pend_clr;
  logic [NREGS-1:0]  pend_d;

  logic [ADDR_W-1:0] waddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic              err_q;

  // Round-robin: a lone requester always wins; only contention moves priority.
  always_comb begin
    contended = wb.alu_valid & wb.lsu_valid;
    alu_gnt   = wb.alu_valid & (~wb.lsu_valid | prio_alu);
    lsu_gnt   = wb.lsu_valid & ~alu_gnt;
    gnt       = alu_gnt | lsu_gnt;
    gnt_rd    = alu_gnt ? wb.alu_rd    : wb.lsu_rd;
    gnt_wdata = alu_gnt ? wb.alu_wdata : wb.lsu_wdata;
  end

  // No bypass from the committing write: the consumer waits one more cycle.
  always_comb begin
    hazard   = pend_q[wb.iss_rs0] | pend_q[wb.iss_rs1] |
               (wb.iss_rd_we & pend_q[wb.iss_rd]);
    iss_fire = wb.iss_valid & ~hazard;
  end

  always_comb begin
    pend_set = '0;
    pend_clr = '0;
    if (iss_fire && wb.iss_rd_we && (wb.iss_rd != '0)) begin
      pend_set[wb.iss_rd] = 1'b1;
    end
    if (we_q) begin
      pend_clr[waddr_q] = 1'b1;
    end
    // Set is applied after clear so a same-cycle collision leaves the bit set.
    pend_d    = (pend_q & ~pend_clr) | pend_set;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_alu <= 1'b1;
    end else if (contended) begin
      prio_alu <= ~prio_alu;
    end
  end

  // x0 grants are consumed but never raise we or touch the scoreboard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      we_q <= gnt & (gnt_rd != '0);
      if (gnt) begin
        waddr_q <= gnt_rd;
        wdata_q <= gnt_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (gnt && (gnt_rd != '0) && !pend_q[gnt_rd]) begin
      err_q <= 1'b1;
    end
  end

  assign wb.iss_ready = ~hazard;
  assign wb.alu_ready = alu_gnt;
  assign wb.lsu_ready = lsu_gnt;
  assign wb.rf_we     = we_q;
  assign wb.rf_waddr  = waddr_q;
  assign wb.rf_wdata  = wdata_q;
  assign wb.pending   = pend_q;
  assign wb.wb_err    = err_q;

endmodule
